// File: rtl/rv_pkg.sv
// Shared RV32 datapath constants used by the register file and the ALU.
package rv_pkg;

  localparam int WORDSIZE = 32;
  localparam int ADDRW    = 5;
  localparam int REGCOUNT = 32;

  localparam logic [ADDRW-1:0] X0_ADDR = '0;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port of the register file: address decode,
// hard-wired x0 and, when REGFILE_BYPASS_EN is defined, write-through of
// the in-flight write data on an address collision.
module regfile_rd_port
  import rv_pkg::*;
#(
  parameter int WORDSIZE = rv_pkg::WORDSIZE,
  parameter int ADDRW    = rv_pkg::ADDRW,
  parameter int REGCOUNT = rv_pkg::REGCOUNT
) (
  input  logic [ADDRW-1:0]    rs_addr,
  input  logic [WORDSIZE-1:0] reg_view [REGCOUNT],
  input  logic                wr_en,
  input  logic [ADDRW-1:0]    wr_addr,
  input  logic [WORDSIZE-1:0] wr_data,
  output logic [WORDSIZE-1:0] rs_data
);

`ifdef REGFILE_BYPASS_EN
  // Select register contents, letting a same-cycle write win except on x0
  always_comb begin
    rs_data = reg_view[rs_addr];
    if (wr_en && (wr_addr == rs_addr)) begin
      rs_data = wr_data;
    end
    if (rs_addr == X0_ADDR) begin
      rs_data = '0;
    end
  end
`else
  // The write-side inputs only matter for the bypass build
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};

  // Select register contents; a pending write is not visible until the edge
  always_comb begin
    rs_data = reg_view[rs_addr];
    if (rs_addr == X0_ADDR) begin
      rs_data = '0;
    end
  end
`endif

endmodule

// File: rtl/regfile.sv
// RV32 integer register file: two asynchronous read ports, one synchronous
// write port, x0 hard-wired to zero and asynchronous active-low clear.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-through).
module regfile
  import rv_pkg::*;
#(
  parameter int WORDSIZE = rv_pkg::WORDSIZE,
  parameter int REGCOUNT = rv_pkg::REGCOUNT,
  parameter int ADDRW    = rv_pkg::ADDRW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDRW-1:0]    rs1_addr,
  input  logic [ADDRW-1:0]    rs2_addr,
  input  logic [ADDRW-1:0]    rd_addr,
  input  logic [WORDSIZE-1:0] rd_data,
  input  logic                reg_write,
  output logic [WORDSIZE-1:0] rs1_data,
  output logic [WORDSIZE-1:0] rs2_data
);

  // x0 has no storage; entries 1..REGCOUNT-1 are plain flops so the clear
  // stays asynchronous and the reads stay combinational
  logic [WORDSIZE-1:0] regs_q   [1:REGCOUNT-1];
  logic [WORDSIZE-1:0] reg_view [REGCOUNT];
  logic                wr_en;

  // Writes are dropped while reset is held and never target x0
  assign wr_en = reg_write && rst_n && (rd_addr != X0_ADDR);

  // Clear every register on reset, otherwise capture the addressed write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < REGCOUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < REGCOUNT; i++) begin
        if (wr_en && (rd_addr == ADDRW'(i))) begin
          regs_q[i] <= rd_data;
        end
      end
    end
  end

  // Present a full REGCOUNT-entry view to the read ports with x0 tied low
  always_comb begin
    reg_view[0] = '0;
    for (int i = 1; i < REGCOUNT; i++) begin
      reg_view[i] = regs_q[i];
    end
  end

  regfile_rd_port #(
    .WORDSIZE(WORDSIZE),
    .ADDRW   (ADDRW),
    .REGCOUNT(REGCOUNT)
  ) u_rd_port1 (
    .rs_addr (rs1_addr),
    .reg_view(reg_view),
    .wr_en   (wr_en),
    .wr_addr (rd_addr),
    .wr_data (rd_data),
    .rs_data (rs1_data)
  );

  regfile_rd_port #(
    .WORDSIZE(WORDSIZE),
    .ADDRW   (ADDRW),
    .REGCOUNT(REGCOUNT)
  ) u_rd_port2 (
    .rs_addr (rs2_addr),
    .reg_view(reg_view),
    .wr_en   (wr_en),
    .wr_addr (rd_addr),
    .wr_data (rd_data),
    .rs_data (rs2_data)
  );

endmodule
